seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed display scanner: steps through digit slots, double-buffers
// the displayed word so it only changes between frames, and drives active-low anodes.
module seg_scan_ctrl #(
  parameter int CLK_DIV = 100000,
  parameter int DEAD    = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        load,
  input  logic [7:0]  digit_en,
  input  logic        blank_lz,
  output logic [31:0] data_out,
  output logic [2:0]  sel,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    sel_reg, sel_next;
  logic [31:0]   data_reg, data_next;
  logic [31:0]   shadow_reg, shadow_next;
  logic          pending_reg, pending_next;
  logic          frame_done_reg, frame_done_next;
  logic          rst_hold_reg;

  logic          slot_end;
  logic          frame_end;
  logic          lit_window;
  logic [7:0]    visible;

  assign slot_end  = (cnt_reg == CNT_LAST);
  assign frame_end = slot_end && (sel_reg == 3'd7);

  // With no dead time the anode is lit for the whole slot; avoids a constant compare.
  generate
    if (DEAD == 0) begin : g_no_dead
      assign lit_window = 1'b1;
    end else begin : g_dead
      localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD);
      assign lit_window = (cnt_reg >= DEAD_CNT);
    end
  endgenerate

  // Digit k is a leading zero when nibbles k..7 of the displayed word are all zero.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_vis
      if (gi == 0) begin : g_lsd
        assign visible[gi] = digit_en[gi];
      end else begin : g_upper
        assign visible[gi] = digit_en[gi] &
                             ~(blank_lz & (data_reg[31:4*gi] == '0));
      end
    end
  endgenerate

  always_comb begin
    cnt_next        = slot_end ? '0 : cnt_reg + 1'b1;
    sel_next        = slot_end ? sel_reg + 3'd1 : sel_reg;
    frame_done_next = frame_end;
    data_next       = data_reg;
    shadow_next     = shadow_reg;
    pending_next    = pending_reg;

    if (load && frame_end) begin
      data_next    = din;
      shadow_next  = din;
      pending_next = 1'b0;
    end else begin
      if (frame_end && pending_reg) begin
        data_next    = shadow_reg;
        pending_next = 1'b0;
      end
      if (load) begin
        shadow_next  = din;
        pending_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      sel_reg        <= 3'd0;
      data_reg       <= 32'd0;
      shadow_reg     <= 32'd0;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      rst_hold_reg   <= 1'b1;
    end else begin
      cnt_reg        <= cnt_next;
      sel_reg        <= sel_next;
      data_reg       <= data_next;
      shadow_reg     <= shadow_next;
      pending_reg    <= pending_next;
      frame_done_reg <= frame_done_next;
      rst_hold_reg   <= 1'b0;
    end
  end

  // rst_hold_reg keeps the anodes dark while reset is held, even when DEAD is 0.
  assign an = (!rst_hold_reg && lit_window && visible[sel_reg]) ?
              ~(8'd1 << sel_reg) : 8'hFF;

  assign data_out   = data_reg;
  assign sel        = sel_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a cycle-count based reference model,
// plus directed frame-level checks for loading, blanking and masking.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEAD    = 1;
  localparam int FRAME   = 8 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = 32'd0;
  logic        load = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic        blank_lz = 1'b0;
  logic [31:0] data_out;
  logic [2:0]  sel;
  logic [7:0]  an;
  logic        frame_done;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .din(din), .load(load), .digit_en(digit_en),
    .blank_lz(blank_lz), .data_out(data_out), .sel(sel), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: m_n counts cycles since reset; slot and digit follow by division.
  int          m_n = 0;
  logic [31:0] m_data = 32'd0;
  logic [31:0] m_shadow = 32'd0;
  bit          m_pend = 1'b0;
  bit          m_fd = 1'b0;
  bit          m_hold = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_an();
    int  cnt = m_n % CLK_DIV;
    int  s = (m_n / CLK_DIV) % 8;
    int  msd = 0;
    bit  vis;
    for (int k = 0; k < 8; k++)
      if (m_data[4*k +: 4] != 4'd0) msd = k;
    vis = digit_en[s] && (!blank_lz || s == 0 || s <= msd);
    if (m_hold || cnt < DEAD || !vis) return 8'hFF;
    return ~(8'h01 << s);
  endfunction

  task automatic tick();
    bit bound;
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_data = 0; m_shadow = 0; m_pend = 0; m_fd = 0; m_hold = 1;
    end else begin
      bound = (m_n % FRAME) == FRAME - 1;
      m_fd = bound;
      if (load && bound) begin
        m_data = din; m_shadow = din; m_pend = 0;
      end else begin
        if (bound && m_pend) begin
          m_data = m_shadow; m_pend = 0;
        end
        if (load) begin
          m_shadow = din; m_pend = 1;
        end
      end
      m_n++;
      m_hold = 0;
    end
    #1;
    check_val("sel", {29'd0, sel}, (m_n / CLK_DIV) % 8);
    check_val("data_out", data_out, m_data);
    check_val("an", {24'd0, an}, {24'd0, exp_an()});
    check_val("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
  endtask

  task automatic wait_phase(input int ph);
    int guard = 0;
    while ((m_n % FRAME) != ph && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    if ((m_n % FRAME) != ph) check_val("phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic collect_frame(input string tag, input logic [7:0] exp_mask);
    logic [7:0] fired;
    wait_phase(0);
    fired = ~an;
    repeat (FRAME - 1) begin
      tick();
      fired |= ~an;
    end
    check_val(tag, {24'd0, fired}, {24'd0, exp_mask});
  endtask

  initial begin
    rst = 1'b1;
    tick();
    check_val("rst_an", {24'd0, an}, 32'h0000_00FF);
    tick();
    rst = 1'b0;

    // Plain scan, two frames
    repeat (2 * FRAME) tick();

    // Load mid-frame during slot 3
    wait_phase(3 * CLK_DIV);
    din = 32'h1234_5678; load = 1'b1;
    tick();
    load = 1'b0; din = 32'd0;
    check_val("load_held", data_out, 32'd0);
    wait_phase(0);
    check_val("load_mid", data_out, 32'h1234_5678);
    check_val("load_fd", {31'd0, frame_done}, 32'd1);

    // Load coinciding with the frame boundary
    wait_phase(FRAME - 1);
    din = 32'hCAFE_F00D; load = 1'b1;
    tick();
    load = 1'b0; din = 32'd0;
    check_val("coincident", data_out, 32'hCAFE_F00D);
    repeat (FRAME + 2) tick();
    check_val("coincident_hold", data_out, 32'hCAFE_F00D);

    // Leading-zero blanking and digit mask
    rst = 1'b1; tick(); rst = 1'b0;
    din = 32'h0000_0A05; load = 1'b1;
    tick();
    load = 1'b0; din = 32'd0;
    wait_phase(0);
    check_val("lz_data", data_out, 32'h0000_0A05);
    blank_lz = 1'b1; digit_en = 8'hFF;
    tick();
    collect_frame("lz_on", 8'h07);
    blank_lz = 1'b0;
    tick();
    collect_frame("lz_off", 8'hFF);
    digit_en = 8'b1010_0101;
    tick();
    collect_frame("mask", 8'hA5);
    digit_en = 8'hFF;

    // Reset mid-frame discards a pending load
    wait_phase(5 * CLK_DIV + 1);
    din = 32'h55AA_55AA; load = 1'b1;
    tick();
    load = 1'b0;
    wait_phase(6 * CLK_DIV + 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_data", data_out, 32'd0);
    check_val("rst_sel", {29'd0, sel}, 32'd0);
    check_val("rst_an_mid", {24'd0, an}, 32'h0000_00FF);
    tick();
    wait_phase(1);
    check_val("rst_no_update", data_out, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 11) == 0) ||
             ((m_n % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1);
      din  = $urandom >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      tick();
    end
    rst = 1'b0; load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
